// File: rtl/enc_dec_pkg.sv
// rtl/enc_dec_pkg.sv - shared constants and helpers for the 2/4 encoder and decoder blocks
package enc_dec_pkg;

  localparam int CODE_W   = 2;
  localparam int ONEHOT_W = 4;

  // Two-state hold FSM encoding shared by encoder and decoder sides
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  function automatic logic [ONEHOT_W-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    return ONEHOT_W'(1) << code;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - loadable down-counter with zero flag for the hold interval
module hold_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; never decrement below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register with synchronous reset to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder2_4_hold.sv
// rtl/decoder2_4_hold.sv - registered 2-to-4 one-hot decoder with handshake and hold time
module decoder2_4_hold
  import enc_dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CODE_W-1:0]   code_in,
  input  logic                valid_in,
  output logic                ready_out,
  output logic [ONEHOT_W-1:0] onehot_out,
  output logic                active_out,
  output logic                done_pulse
);

  logic [0:0]          state_q;
  logic [0:0]          state_d;
  logic [ONEHOT_W-1:0] onehot_q;
  logic [ONEHOT_W-1:0] onehot_d;
  logic                tmr_load;
  logic                tmr_dec;
  logic                tmr_zero;
  logic                handshake;

  // Remaining hold cycles after the first one; zero means this is the last cycle
  hold_timer #(
    .CNT_W(CNT_W)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(CNT_W'(HOLD_CYCLES - 1)),
    .dec_en  (tmr_dec),
    .zero    (tmr_zero)
  );

  assign ready_out  = (state_q == ST_IDLE) && !rst;
  assign handshake  = valid_in && ready_out;
  assign onehot_out = onehot_q;
  assign active_out = |onehot_q;
  assign done_pulse = (state_q == ST_HOLD) && tmr_zero;

  // Next-state logic: latch the decoded code on handshake, release after the hold
  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          onehot_d = code_to_onehot(code_in);
          tmr_load = 1'b1;
          state_d  = ST_HOLD;
        end
      end
      default: begin
        if (tmr_zero) begin
          onehot_d = '0;
          state_d  = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
    endcase
  end

  // State and output registers; reset drops any hold in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
    end
  end

endmodule

// File: tb/tb_decoder2_4_hold.sv
// tb/tb_decoder2_4_hold.sv - self-checking bench for decoder2_4_hold (HOLD_CYCLES 3 and 1)
module tb_decoder2_4_hold;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] code_in = 2'b00;
  logic       valid_in = 1'b0;

  logic       ready3, active3, done3;
  logic [3:0] onehot3;
  logic       ready1, active1, done1;
  logic [3:0] onehot1;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;
  int done3_cnt = 0;
  int mark;

  // Reference model: each instance remembers the edge and code of its last handshake
  int         hold_len [2] = '{3, 1};
  bit         have     [2] = '{1'b0, 1'b0};
  int         hs_edge  [2] = '{0, 0};
  logic [1:0] hs_code  [2] = '{2'b00, 2'b00};

  always #5 clk = ~clk;

  decoder2_4_hold #(.HOLD_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .code_in(code_in), .valid_in(valid_in),
    .ready_out(ready3), .onehot_out(onehot3), .active_out(active3), .done_pulse(done3)
  );

  decoder2_4_hold #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .code_in(code_in), .valid_in(valid_in),
    .ready_out(ready1), .onehot_out(onehot1), .active_out(active1), .done_pulse(done1)
  );

  function automatic bit m_act(int i);
    return have[i] && ((ecnt - hs_edge[i]) < hold_len[i]);
  endfunction

  function automatic bit m_ready(int i);
    return !rst && !m_act(i);
  endfunction

  function automatic logic [3:0] m_onehot(int i);
    logic [3:0] one;
    one = 4'b0001;
    return m_act(i) ? (one << hs_code[i]) : 4'b0000;
  endfunction

  function automatic bit m_done(int i);
    return m_act(i) && ((ecnt - hs_edge[i]) == hold_len[i] - 1);
  endfunction

  task automatic chk_bit(string tag, int i, logic got, logic exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[H=%0d] edge=%0d got=%b exp=%b", tag, hold_len[i], ecnt, got, exp);
    end
  endtask

  task automatic chk_inst(int i, logic [3:0] oh, logic act, logic dn, logic rdy);
    n_tests++;
    assert (oh === m_onehot(i)) else begin
      n_fail++;
      $error("FAIL onehot[H=%0d] edge=%0d got=%b exp=%b", hold_len[i], ecnt, oh, m_onehot(i));
    end
    chk_bit("active", i, act, m_act(i));
    chk_bit("done", i, dn, m_done(i));
    chk_bit("ready", i, rdy, m_ready(i));
  endtask

  // One clock: predict handshakes from pre-edge inputs, advance, then compare
  task automatic step();
    bit hs [2];
    bit rs;
    for (int i = 0; i < 2; i++) hs[i] = valid_in && m_ready(i);
    rs = rst;
    @(posedge clk);
    ecnt++;
    for (int i = 0; i < 2; i++) begin
      if (rs) begin
        have[i] = 1'b0;
      end else if (hs[i]) begin
        have[i]    = 1'b1;
        hs_edge[i] = ecnt;
        hs_code[i] = code_in;
      end
    end
    #1;
    if (done3 === 1'b1) done3_cnt++;
    chk_inst(0, onehot3, active3, done3, ready3);
    chk_inst(1, onehot1, active1, done1, ready1);
  endtask

  task automatic chk_int(string tag, int got, int exp);
    n_tests++;
    assert (got == exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    // Reset with a pending request that must be dropped
    rst = 1'b1; valid_in = 1'b1; code_in = 2'b11;
    step(); step();
    rst = 1'b0; valid_in = 1'b0;
    step();
    chk_bit("ready_after_rst", 0, ready3, 1'b1);

    // Single decode of 10
    valid_in = 1'b1; code_in = 2'b10;
    step();
    valid_in = 1'b0;
    chk_int("single_onehot", int'(onehot3), 4);
    repeat (4) step();

    // All codes back-to-back with valid held high
    mark = done3_cnt;
    valid_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      code_in = 2'(c);
      repeat (4) step();
    end
    valid_in = 1'b0;
    step();
    chk_int("b2b_done_count", done3_cnt - mark, 4);

    // Input churn during a hold
    valid_in = 1'b1; code_in = 2'b01;
    step();
    valid_in = 1'b0;
    for (int j = 0; j < 3; j++) begin
      code_in = code_in ^ 2'b11;
      step();
    end
    step();

    // Reset in the second hold cycle
    mark = done3_cnt;
    valid_in = 1'b1; code_in = 2'b11;
    step();
    valid_in = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk_int("rst_mid_onehot", int'(onehot3), 0);
    rst = 1'b0;
    repeat (3) step();
    chk_int("rst_mid_done_count", done3_cnt - mark, 0);

    // Single-cycle hold instance
    valid_in = 1'b1; code_in = 2'b00;
    step();
    valid_in = 1'b0;
    chk_int("h1_onehot", int'(onehot1), 1);
    chk_bit("h1_done", 1, done1, 1'b1);
    step();
    chk_bit("h1_ready_after", 1, ready1, 1'b1);
    repeat (3) step();

    // Randomized traffic against the model
    for (int j = 0; j < 400; j++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      code_in  = 2'($urandom_range(0, 3));
      rst      = ($urandom_range(0, 31) == 0);
      step();
    end
    rst = 1'b0; valid_in = 1'b0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
